// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory port-B arbiter.
//   DEF_NUM_REQ / DEF_MEM_LAT : default requester count and memory read latency
//   INSTR_W                   : instruction word width
//   req_id_t / inflight_t     : requester id and in-flight slot at default sizing
//   wrap_inc                  : modulo increment used for the round-robin pointer
package imem_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 2;
  localparam int unsigned DEF_MEM_LAT = 1;
  localparam int unsigned INSTR_W     = 32;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } inflight_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_rr.sv
// Purely combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index this cycle
//   gnt    : one-hot grant (zero when nothing requested)
//   win_id : index of the winner (zero when nothing requested)
//   any    : at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    win_id,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  int unsigned          off;
  int unsigned          pos;

  // Rotate the request vector so the pointer position sits at bit 0, then
  // take the lowest set bit and map it back to an absolute index.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    off   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    pos    = (32'(ptr) + off) % NUM_REQ;
    any    = found;
    win_id = found ? ID_W'(pos) : '0;
    gnt    = found ? (NUM_REQ'(1) << pos) : '0;
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares instruction-memory read port B between NUM_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester level request, held until gnt
//   req_addr   : packed addresses, requester i at [i*WIDTH +: WIDTH]
//   gnt        : one-hot grant, address accepted this cycle
//   rvalid     : one-hot, rdata belongs to that requester this cycle
//   rdata      : returned word (holds its last value when no rvalid)
//   busy       : any read in flight
//   mem_addr   : to memory address_b
//   mem_q      : from memory data_b, valid MEM_LAT cycles after the address
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rvalid,
  output logic [INSTR_W-1:0]       rdata,
  output logic                     busy,
  output logic [WIDTH-1:0]         mem_addr,
  input  logic [INSTR_W-1:0]       mem_q
);

  // Id and slot types sized from this instance's NUM_REQ.
  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned SLOT_W = ID_W + 1;
  localparam int unsigned PIPE_W = MEM_LAT * SLOT_W;

  typedef logic [ID_W-1:0] id_t;
  typedef struct packed {
    logic valid;
    id_t  id;
  } flight_t;

  id_t                ptr;
  id_t                win_id;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_any;
  logic               grant;
  logic [WIDTH-1:0]   addr_arr [NUM_REQ];
  logic [WIDTH-1:0]   win_addr;
  logic [WIDTH-1:0]   addr_q;
  flight_t            issue;
  flight_t            head;
  flight_t [MEM_LAT-1:0] pipe;
  logic [INSTR_W-1:0] rdata_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .win_id (win_id),
    .any    (arb_any)
  );

  always_comb begin
    grant    = rst_n && arb_any;
    gnt      = grant ? arb_gnt : '0;
    win_addr = addr_arr[win_id];
    mem_addr = grant ? win_addr : addr_q;
    // Empty slots carry id 0 so busy can be a plain reduction of the pipe.
    issue.valid = grant;
    issue.id    = grant ? win_id : '0;
    head        = pipe[MEM_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      addr_q  <= '0;
      pipe    <= '0;
      rdata_q <= '0;
    end else begin
      if (grant) begin
        ptr    <= id_t'(wrap_inc(32'(win_id), NUM_REQ));
        addr_q <= win_addr;
      end
      // Shift toward the head; the size cast drops the oldest slot.
      pipe <= PIPE_W'({pipe, issue});
      if (head.valid) begin
        rdata_q <= mem_q;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (rst_n && head.valid) begin
      rvalid = NUM_REQ'(1) << head.id;
    end
    rdata = head.valid ? mem_q : rdata_q;
    busy  = rst_n && (pipe != '0);
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

  typedef struct {
    int          due;
    logic [1:0]  mask;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [1:0]  req1, req3, gnt1, gnt3, rv1, rv3;
  logic [31:0] addr1, addr3, rd1, rd3, q1, q3;
  logic        busy1, busy3;
  logic [15:0] ma1, ma3, p3a, p3b;

  logic [1:0]  obs_gnt, obs_rv;
  logic [31:0] obs_rd;
  logic [15:0] obs_addr;
  logic        obs_busy;

  resp_t       sb[$];
  logic [15:0] hold [2];
  int          cyc;
  int          n_vec;
  int          n_err;

  always #5 clk = ~clk;

  imem_port_arbiter #(.WIDTH(16), .NUM_REQ(2), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_addr(addr1), .gnt(gnt1),
    .rvalid(rv1), .rdata(rd1), .busy(busy1), .mem_addr(ma1), .mem_q(q1)
  );

  imem_port_arbiter #(.WIDTH(16), .NUM_REQ(2), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .req_addr(addr3), .gnt(gnt3),
    .rvalid(rv3), .rdata(rd3), .busy(busy3), .mem_addr(ma3), .mem_q(q3)
  );

  // Memory models: word[a] = a*3, latency 1 and 3.
  always @(posedge clk) begin
    q1  <= 32'(ma1) * 32'd3;
    p3a <= ma3;
    p3b <= p3a;
    q3  <= 32'(p3b) * 32'd3;
  end

  assign obs_gnt  = sel ? gnt3  : gnt1;
  assign obs_rv   = sel ? rv3   : rv1;
  assign obs_rd   = sel ? rd3   : rd1;
  assign obs_addr = sel ? ma3   : ma1;
  assign obs_busy = sel ? busy3 : busy1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected response of any grant,
  // then check combinational and returned outputs on the falling edge.
  task automatic step(input logic rst, input logic [1:0] r, input logic [15:0] a0,
                      input logic [15:0] a1, input logic [1:0] eg);
    int          lat;
    logic        bexp;
    logic [15:0] ea;
    resp_t       e;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = rst;
    if (sel == 1'b0) begin
      req1 = r; addr1 = {a1, a0}; req3 = '0;
    end else begin
      req3 = r; addr3 = {a1, a0}; req1 = '0;
    end
    lat = sel ? 3 : 1;
    if (!rst) begin
      sb.delete();
      hold[0] = '0;
      hold[1] = '0;
    end
    bexp = (sb.size() > 0) && (sb[0].due < cyc + lat);
    ea   = (eg == 2'b01) ? a0 : (eg == 2'b10) ? a1 : hold[sel];
    if (eg != 2'b00) begin
      hold[sel] = ea;
      e.due  = cyc + lat;
      e.mask = eg;
      e.data = 32'(ea) * 32'd3;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("gnt", 32'(obs_gnt), 32'(eg));
    chk("mem_addr", 32'(obs_addr), 32'(ea));
    chk("busy", 32'(obs_busy), 32'(bexp));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rvalid", 32'(obs_rv), 32'(e.mask));
      chk("rdata", obs_rd, e.data);
    end else begin
      chk("rvalid_idle", 32'(obs_rv), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; cyc = 0; n_vec = 0; n_err = 0;
    req1 = 2'b11; req3 = 2'b00; addr1 = '0; addr3 = '0;
    hold[0] = '0; hold[1] = '0;

    // Reset held with both requesting, then first grant to requester 0.
    step(1'b0, 2'b11, 16'h0000, 16'h0000, 2'b00);
    step(1'b0, 2'b11, 16'h0000, 16'h0000, 2'b00);
    step(1'b1, 2'b11, 16'h0100, 16'h0200, 2'b01);

    // Single read by requester 1.
    step(1'b1, 2'b10, 16'h0000, 16'h0010, 2'b10);
    step(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00);

    // Contention: strict alternation.
    for (int i = 0; i < 6; i++)
      step(1'b1, 2'b11, 16'(16'h0020 + i), 16'(16'h0040 + i),
           (i % 2 == 0) ? 2'b01 : 2'b10);
    step(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00);

    // Withdraw: req0 present for one losing cycle only; idle address holds.
    step(1'b1, 2'b01, 16'h0077, 16'h0000, 2'b01);
    step(1'b1, 2'b11, 16'h0099, 16'h0055, 2'b10);
    step(1'b1, 2'b00, 16'h0099, 16'h0000, 2'b00);
    step(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00);
    step(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00);

    // All-ones address passes through.
    step(1'b1, 2'b10, 16'h0000, 16'hFFFF, 2'b10);
    step(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00);

    // Mid-flight reset: response discarded, pointer back to 0.
    step(1'b1, 2'b01, 16'h0042, 16'h0000, 2'b01);
    step(1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00);
    step(1'b1, 2'b11, 16'h000A, 16'h000B, 2'b01);
    step(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00);
    step(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00);

    // MEM_LAT=3 instance: back-to-back reads across the address wrap,
    // then contention with reads still in flight.
    sel = 1'b1;
    step(1'b1, 2'b01, 16'h1FFE, 16'h0000, 2'b01);
    step(1'b1, 2'b01, 16'h1FFF, 16'h0000, 2'b01);
    step(1'b1, 2'b01, 16'h0000, 16'h0000, 2'b01);
    step(1'b1, 2'b01, 16'h0001, 16'h0000, 2'b01);
    step(1'b1, 2'b11, 16'h0300, 16'h0400, 2'b10);
    step(1'b1, 2'b11, 16'h0300, 16'h0401, 2'b01);
    for (int i = 0; i < 4; i++)
      step(1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one read port of the instruction memory (port B, 32-bit words) between NUM_REQ independent read requesters.
- Typical requesters: the debug/loader readback path and the sprite/asset fetch engine. Port A stays dedicated to CPU fetch.
- Arbitrates round-robin, drives the memory address, and tracks the fixed memory read latency.
- Routes each returned word back to the requester that issued it, with a per-requester valid pulse.

Parameters:
- WIDTH, 16, address width; matches the instruction memory address ports.
- NUM_REQ, 2, number of requesters; legal range 2..8.
- MEM_LAT, 1, cycles from address presented on mem_addr to word valid on mem_q; legal range 1..3.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester read request; level, held until granted.
- req_addr  in  NUM_REQ*WIDTH  packed word addresses; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  NUM_REQ  one-hot grant; address accepted this cycle.
- rvalid  out  NUM_REQ  one-hot; rdata is valid for that requester this cycle.
- rdata  out  32  returned instruction word.
- busy  out  1  high while any read is in flight.
- mem_addr  out  WIDTH  to the instruction memory address_b.
- mem_q  in  32  from the instruction memory data_b.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Round-robin pointer = 0; in-flight pipeline cleared; mem_addr register = 0.
  - gnt, rvalid and busy are forced to 0 while rst_n is low.
- Arbitration (combinational, same cycle):
  - The winner is the first asserted req at or after the pointer, wrapping modulo NUM_REQ.
  - gnt is one-hot, or zero if no req is asserted.
  - At most one grant per cycle; one new read may start every cycle (fully pipelined).
- Pointer update: on a grant to requester k, the pointer becomes (k+1) mod NUM_REQ at the next edge. With no grant, the pointer holds.
- mem_addr:
  - With a grant, mem_addr = req_addr of the winner (combinational), and that value is also registered.
  - With no grant, mem_addr holds the last granted address (registered copy) so the memory input does not toggle.
- Handshake:
  - A requester keeps req and req_addr stable until it sees gnt in the same cycle.
  - In the cycle after gnt, the requester may drop req or present a new address.
  - req may be withdrawn before grant without side effects.
- Response pipeline:
  - A shift register of depth MEM_LAT carries {valid, id} per issued read.
  - Exactly MEM_LAT cycles after gnt[k], rvalid[k]=1 for one cycle and rdata = mem_q.
  - Responses are returned in issue order, one per cycle maximum, with no gaps added.
- rdata: equals mem_q whenever any rvalid bit is set; otherwise it holds its last value. Consumers must not sample rdata without rvalid.
- busy = OR of the valid bits in the pipeline.
- Boundary conditions:
  - All requesters continuously requesting: strict rotation 0,1,..,N-1,0; no requester waits more than NUM_REQ-1 cycles.
  - Same requester back-to-back alone: granted every cycle.
  - Address wrap (all ones): passed through unmodified; no address arithmetic is done here.
  - A requester issuing a new request while its previous response is still in flight is legal; responses stay ordered.
  - rst_n asserted mid-operation: in-flight responses are discarded with no rvalid, even though the memory still produces data.
  - First grant after reset goes to the lowest-indexed requester that is requesting.
- No write path: memory write enables stay tied low outside this block.

Decomposition:
- Package imem_arb_pkg holds:
  - default NUM_REQ, MEM_LAT and INSTR_W=32;
  - typedef req_id_t (logic [$clog2(NUM_REQ)-1:0]);
  - typedef struct inflight_t {logic valid; req_id_t id;}.
- Sub-module rr_arbiter (req vector + pointer → one-hot gnt + winner id), purely combinational and reusable.
- Pointer, address register and response pipeline stay in imem_port_arbiter.

Test Plan:
1. Reset: hold rst_n=0 with req=2'b11 → gnt=0, rvalid=0, busy=0. Release rst_n → first gnt=2'b01.
2. Single read, MEM_LAT=1, memory model word[a]=a*3:
   - requester 1 reqs addr 0x0010 → gnt=2'b10 and mem_addr=0x0010 in cycle t;
   - cycle t+1: rvalid=2'b10, rdata=0x30.
3. Contention, req=2'b11 held for 6 cycles:
   - grants alternate 01,10,01,10,01,10;
   - each rvalid follows its grant by MEM_LAT with the matching data.
4. Withdraw and hold:
   - req0 asserted 1 cycle then dropped while req1 holds the grant → req0 never receives gnt or rvalid;
   - idle cycles: mem_addr keeps the last value.
5. MEM_LAT=3, requester 0 issues 4 back-to-back reads at 0x1FFE,0x1FFF,0x0000,0x0001:
   - rvalid[0] for 4 consecutive cycles starting 3 cycles after the first gnt, data in order;
   - busy high throughout.
6. Mid-flight reset: pulse rst_n low 1 cycle after a grant → no rvalid for that read, pointer = 0 afterward.
